// File: rtl/wb_stage_mlane.sv
// wb_stage_mlane -- multi-lane writeback stage.
//
// Takes a group of up to LANES instructions from MEM and retires them one
// lane per cycle in ascending order, so the single-port debug trace sees
// every retirement. MEM is held off through ws_allowin until the group
// finishes. With exceptions enabled, the oldest faulting lane kills itself
// and every younger lane. A one-cycle ws_flush pulse then reports the
// fault PC and ecode.
//
// Build option: define WB_EXCEPTION_EN to enable fault/kill handling and
// the flush outputs. When it is undefined, ms_ex/ms_ecode are ignored and
// ws_flush/ws_ex_pc/ws_ecode are tied to 0.
//
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   ws_allowin         WB can accept a group this cycle
//   ms_to_ws_valid     MEM offers a group
//   ms_lane_valid      per-lane occupancy
//   ms_pc/ms_rf_*      per-lane PC, regfile write enable/address/data
//   ms_ex/ms_ecode     per-lane exception flag and code
//   ws_rf_*            regfile write port (one lane strobed per cycle)
//   ws_flush/ws_ex_pc/ws_ecode  exception flush pulse and its PC/code
//   debug_wb_*         retirement trace
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no group held
// EMIT0 | lane 0 retiring, or fault-only cycle when nothing retires
// EMIT1 | lane 1 retiring

module wb_stage_mlane #(
   parameter int LANES  = 2,
   parameter int DATA_W = 32,
   parameter int AW     = 5,
   parameter int PC_W   = 32
) (
   input  logic                     clk,
   input  logic                     reset,
   output logic                     ws_allowin,
   input  logic                     ms_to_ws_valid,
   input  logic [LANES-1:0]         ms_lane_valid,
   input  logic [LANES*PC_W-1:0]    ms_pc,
   input  logic [LANES-1:0]         ms_rf_we,
   input  logic [LANES*AW-1:0]      ms_rf_waddr,
   input  logic [LANES*DATA_W-1:0]  ms_rf_wdata,
   input  logic [LANES-1:0]         ms_ex,
   input  logic [LANES*6-1:0]       ms_ecode,
   output logic [LANES-1:0]         ws_rf_we,
   output logic [LANES*AW-1:0]      ws_rf_waddr,
   output logic [LANES*DATA_W-1:0]  ws_rf_wdata,
   output logic                     ws_flush,
   output logic [PC_W-1:0]          ws_ex_pc,
   output logic [5:0]               ws_ecode,
   output logic [31:0]              debug_wb_pc,
   output logic [3:0]               debug_wb_rf_we,
   output logic [4:0]               debug_wb_rf_wnum,
   output logic [31:0]              debug_wb_rf_wdata
);

   typedef enum logic [1:0] {S_IDLE, S_EMIT0, S_EMIT1} state_t;

   state_t state, state_nxt;
   logic   ws_valid;

   logic [LANES-1:0]         lane_valid_q, rf_we_q;
   logic [LANES*PC_W-1:0]    pc_q;
   logic [LANES*AW-1:0]      waddr_q;
   logic [LANES*DATA_W-1:0]  wdata_q;
`ifdef WB_EXCEPTION_EN
   logic [LANES-1:0]         ex_q;
   logic [LANES*6-1:0]       ecode_q;
`endif

   // Two-lane views of the latched group; lanes beyond LANES read as empty
   // so the control logic is written once for both legal widths.
   logic [1:0]        lv2, we2;
   logic [PC_W-1:0]   pc2    [2];
   logic [AW-1:0]     waddr2 [2];
   logic [DATA_W-1:0] wdata2 [2];
`ifdef WB_EXCEPTION_EN
   logic [1:0]        ex2;
   logic [5:0]        ecode2 [2];
`endif

   for (genvar g = 0; g < 2; g++) begin : g_view
      if (g < LANES) begin : g_live
         assign lv2[g]    = lane_valid_q[g];
         assign we2[g]    = rf_we_q[g];
         assign pc2[g]    = pc_q[g*PC_W +: PC_W];
         assign waddr2[g] = waddr_q[g*AW +: AW];
         assign wdata2[g] = wdata_q[g*DATA_W +: DATA_W];
`ifdef WB_EXCEPTION_EN
         assign ex2[g]    = ex_q[g];
         assign ecode2[g] = ecode_q[g*6 +: 6];
`endif
      end else begin : g_absent
         assign lv2[g]    = 1'b0;
         assign we2[g]    = 1'b0;
         assign pc2[g]    = '0;
         assign waddr2[g] = '0;
         assign wdata2[g] = '0;
`ifdef WB_EXCEPTION_EN
         assign ex2[g]    = 1'b0;
         assign ecode2[g] = '0;
`endif
      end
   end

   // Retire set: lanes older than the first fault (all valid lanes if none).
   logic ret0, ret1, fault_any;
`ifdef WB_EXCEPTION_EN
   logic f0, f1, fault_sel;
   assign f0        = lv2[0] & ex2[0];
   assign f1        = lv2[1] & ex2[1];
   assign fault_any = f0 | f1;
   assign fault_sel = ~f0;
   assign ret0      = lv2[0] & ~f0;
   assign ret1      = lv2[1] & ~fault_any;
`else
   logic unused_ex;
   assign unused_ex = ^{ms_ex, ms_ecode};
   assign fault_any = 1'b0;
   assign ret0      = lv2[0];
   assign ret1      = lv2[1];
`endif

   logic ready_go, flush, capture;

   assign ready_go   = ((state == S_EMIT0) && !ret1) || (state == S_EMIT1);
   assign flush      = ws_valid && ready_go && fault_any;
   assign ws_allowin = !ws_valid || (ready_go && !flush);
   assign capture    = ms_to_ws_valid && ws_allowin;

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (capture) state_nxt = S_EMIT0;
         S_EMIT0: begin
            if (ret1)         state_nxt = S_EMIT1;
            else if (capture) state_nxt = S_EMIT0;
            else              state_nxt = S_IDLE;
         end
         S_EMIT1: state_nxt = capture ? S_EMIT0 : S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= S_IDLE;
         ws_valid     <= 1'b0;
         lane_valid_q <= '0;
         rf_we_q      <= '0;
         pc_q         <= '0;
         waddr_q      <= '0;
         wdata_q      <= '0;
`ifdef WB_EXCEPTION_EN
         ex_q         <= '0;
         ecode_q      <= '0;
`endif
      end else begin
         state <= state_nxt;
         if (capture) begin
            ws_valid     <= 1'b1;
            lane_valid_q <= ms_lane_valid;
            rf_we_q      <= ms_rf_we;
            pc_q         <= ms_pc;
            waddr_q      <= ms_rf_waddr;
            wdata_q      <= ms_rf_wdata;
`ifdef WB_EXCEPTION_EN
            ex_q         <= ms_ex;
            ecode_q      <= ms_ecode;
`endif
         end else if (ready_go) begin
            ws_valid <= 1'b0;
         end
      end
   end

   // Which lane (if any) retires this cycle.
   logic ret_valid, ret_lane, fault_only;

   always_comb begin
      ret_valid  = 1'b0;
      ret_lane   = 1'b0;
      fault_only = 1'b0;
      case (state)
         S_EMIT0: begin
            ret_valid  = ret0;
            fault_only = !ret0;
         end
         S_EMIT1: begin
            ret_valid = ret1;
            ret_lane  = 1'b1;
         end
         default: ;
      endcase
   end

   for (genvar g = 0; g < LANES; g++) begin : g_out
      logic hit;
      assign hit = ret_valid && (ret_lane == 1'(g));
      assign ws_rf_we[g]                   = hit & we2[g];
      assign ws_rf_waddr[g*AW +: AW]       = hit ? waddr2[g] : '0;
      assign ws_rf_wdata[g*DATA_W +: DATA_W] = hit ? wdata2[g] : '0;
   end

   always_comb begin
      debug_wb_pc       = '0;
      debug_wb_rf_we    = '0;
      debug_wb_rf_wnum  = '0;
      debug_wb_rf_wdata = '0;
      if (ret_valid) begin
         debug_wb_pc       = 32'(pc2[ret_lane]);
         debug_wb_rf_we    = {4{we2[ret_lane]}};
         debug_wb_rf_wnum  = 5'(waddr2[ret_lane]);
         debug_wb_rf_wdata = 32'(wdata2[ret_lane]);
      end else if (fault_only) begin
         // Only lane 0 can fault with nothing older to retire.
         debug_wb_pc = 32'(pc2[0]);
      end
   end

   assign ws_flush = flush;
`ifdef WB_EXCEPTION_EN
   assign ws_ex_pc = flush ? pc2[fault_sel]    : '0;
   assign ws_ecode = flush ? ecode2[fault_sel] : '0;
`else
   assign ws_ex_pc = '0;
   assign ws_ecode = '0;
`endif

endmodule

// File: tb/tb_wb_stage_mlane.sv
module tb_wb_stage_mlane;
   localparam int LANES  = 2;
   localparam int DATA_W = 32;
   localparam int AW     = 5;
   localparam int PC_W   = 32;

   logic                    clk = 1'b0;
   logic                    reset;
   logic                    ws_allowin;
   logic                    ms_to_ws_valid;
   logic [LANES-1:0]        ms_lane_valid;
   logic [LANES*PC_W-1:0]   ms_pc;
   logic [LANES-1:0]        ms_rf_we;
   logic [LANES*AW-1:0]     ms_rf_waddr;
   logic [LANES*DATA_W-1:0] ms_rf_wdata;
   logic [LANES-1:0]        ms_ex;
   logic [LANES*6-1:0]      ms_ecode;
   logic [LANES-1:0]        ws_rf_we;
   logic [LANES*AW-1:0]     ws_rf_waddr;
   logic [LANES*DATA_W-1:0] ws_rf_wdata;
   logic                    ws_flush;
   logic [PC_W-1:0]         ws_ex_pc;
   logic [5:0]              ws_ecode;
   logic [31:0]             debug_wb_pc;
   logic [3:0]              debug_wb_rf_we;
   logic [4:0]              debug_wb_rf_wnum;
   logic [31:0]             debug_wb_rf_wdata;

   int n_tests = 0;
   int n_fail  = 0;
   logic [31:0] rf_model [32];

   always #5 clk = ~clk;

   wb_stage_mlane #(.LANES(LANES), .DATA_W(DATA_W), .AW(AW), .PC_W(PC_W)) dut (
      .clk(clk), .reset(reset), .ws_allowin(ws_allowin),
      .ms_to_ws_valid(ms_to_ws_valid), .ms_lane_valid(ms_lane_valid),
      .ms_pc(ms_pc), .ms_rf_we(ms_rf_we), .ms_rf_waddr(ms_rf_waddr),
      .ms_rf_wdata(ms_rf_wdata), .ms_ex(ms_ex), .ms_ecode(ms_ecode),
      .ws_rf_we(ws_rf_we), .ws_rf_waddr(ws_rf_waddr), .ws_rf_wdata(ws_rf_wdata),
      .ws_flush(ws_flush), .ws_ex_pc(ws_ex_pc), .ws_ecode(ws_ecode),
      .debug_wb_pc(debug_wb_pc), .debug_wb_rf_we(debug_wb_rf_we),
      .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic outs(input string tag, input logic [1:0] we, input logic [3:0] dwe,
                       input logic [4:0] wnum, input logic [31:0] wdata, input logic [31:0] pc,
                       input logic allow, input logic fl, input logic [31:0] expc,
                       input logic [5:0] ec);
      check({tag, ".rf_we"},   ws_rf_we,          we);
      check({tag, ".dbg_we"},  debug_wb_rf_we,    dwe);
      check({tag, ".wnum"},    debug_wb_rf_wnum,  wnum);
      check({tag, ".wdata"},   debug_wb_rf_wdata, wdata);
      check({tag, ".pc"},      debug_wb_pc,       pc);
      check({tag, ".allowin"}, ws_allowin,        allow);
      check({tag, ".flush"},   ws_flush,          fl);
      check({tag, ".ex_pc"},   ws_ex_pc,          expc);
      check({tag, ".ecode"},   ws_ecode,          ec);
      if (debug_wb_rf_we != 4'h0) rf_model[debug_wb_rf_wnum] = debug_wb_rf_wdata;
   endtask

   task automatic offer(input logic [1:0] lv, input logic [31:0] p0, input logic [31:0] p1,
                        input logic [1:0] we, input logic [4:0] a0, input logic [4:0] a1,
                        input logic [31:0] d0, input logic [31:0] d1, input logic [1:0] ex,
                        input logic [5:0] e0, input logic [5:0] e1);
      ms_to_ws_valid = 1'b1;
      ms_lane_valid  = lv;
      ms_pc          = {p1, p0};
      ms_rf_we       = we;
      ms_rf_waddr    = {a1, a0};
      ms_rf_wdata    = {d1, d0};
      ms_ex          = ex;
      ms_ecode       = {e1, e0};
   endtask

   task automatic idle();
      ms_to_ws_valid = 1'b0;
      ms_lane_valid  = '0;
      ms_pc          = '0;
      ms_rf_we       = '0;
      ms_rf_waddr    = '0;
      ms_rf_wdata    = '0;
      ms_ex          = '0;
      ms_ecode       = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      for (int i = 0; i < 32; i++) rf_model[i] = '0;
      reset = 1'b1;
      idle();
      repeat (2) @(posedge clk);
      @(negedge clk);
      outs("rst_hold", 2'b00, 4'h0, 5'd0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, 6'h0);
      reset = 1'b0;
      @(negedge clk);
      outs("rst_rel", 2'b00, 4'h0, 5'd0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, 6'h0);
      check("rst_rel.waddr", ws_rf_waddr, 10'h0);
      check("rst_rel.wdata", ws_rf_wdata, 64'h0);

      // Two-lane group, then a back-to-back WAW group offered in the last cycle.
      offer(2'b11, 32'h1C000000, 32'h1C000004, 2'b11, 5'd3, 5'd4, 32'h11, 32'h22, 2'b00, 6'h0, 6'h0);
      @(negedge clk);
      outs("g1_l0", 2'b01, 4'hF, 5'd3, 32'h11, 32'h1C000000, 1'b0, 1'b0, 32'h0, 6'h0);
      check("g1_l0.waddr", ws_rf_waddr, 10'h003);
      check("g1_l0.wdata", ws_rf_wdata, 64'h0000_0000_0000_0011);
      idle();
      @(negedge clk);
      outs("g1_l1", 2'b10, 4'hF, 5'd4, 32'h22, 32'h1C000004, 1'b1, 1'b0, 32'h0, 6'h0);
      check("g1_l1.waddr", ws_rf_waddr, 10'h080);
      check("g1_l1.wdata", ws_rf_wdata, 64'h0000_0022_0000_0000);
      offer(2'b11, 32'h1C000010, 32'h1C000014, 2'b11, 5'd5, 5'd5, 32'hAAAA, 32'hBBBB, 2'b00, 6'h0, 6'h0);
      @(negedge clk);
      outs("waw_l0", 2'b01, 4'hF, 5'd5, 32'hAAAA, 32'h1C000010, 1'b0, 1'b0, 32'h0, 6'h0);
      idle();
      @(negedge clk);
      outs("waw_l1", 2'b10, 4'hF, 5'd5, 32'hBBBB, 32'h1C000014, 1'b1, 1'b0, 32'h0, 6'h0);
      @(negedge clk);
      outs("idle1", 2'b00, 4'h0, 5'd0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, 6'h0);
      check("rf_r5", rf_model[5], 32'hBBBB);

      // Lane 1 faults.
      offer(2'b11, 32'h1C000100, 32'h1C000104, 2'b11, 5'd6, 5'd7, 32'h33, 32'h44, 2'b10, 6'h0, 6'h0B);
      @(negedge clk);
`ifdef WB_EXCEPTION_EN
      outs("ex1_l0", 2'b01, 4'hF, 5'd6, 32'h33, 32'h1C000100, 1'b0, 1'b1, 32'h1C000104, 6'h0B);
      idle();
      @(negedge clk);
      outs("ex1_after", 2'b00, 4'h0, 5'd0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, 6'h0);
      check("rf_r7", rf_model[7], 32'h0);
`else
      outs("ex1_l0", 2'b01, 4'hF, 5'd6, 32'h33, 32'h1C000100, 1'b0, 1'b0, 32'h0, 6'h0);
      idle();
      @(negedge clk);
      outs("ex1_l1", 2'b10, 4'hF, 5'd7, 32'h44, 32'h1C000104, 1'b1, 1'b0, 32'h0, 6'h0);
`endif

      // Lane 0 faults with lane 1 valid.
      offer(2'b11, 32'h1C000200, 32'h1C000204, 2'b11, 5'd8, 5'd9, 32'h55, 32'h66, 2'b01, 6'h05, 6'h0C);
      @(negedge clk);
`ifdef WB_EXCEPTION_EN
      outs("ex0", 2'b00, 4'h0, 5'd0, 32'h0, 32'h1C000200, 1'b0, 1'b1, 32'h1C000200, 6'h05);
      idle();
      @(negedge clk);
      outs("ex0_after", 2'b00, 4'h0, 5'd0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, 6'h0);
      check("rf_r9", rf_model[9], 32'h0);
`else
      outs("ex0_l0", 2'b01, 4'hF, 5'd8, 32'h55, 32'h1C000200, 1'b0, 1'b0, 32'h0, 6'h0);
      idle();
      @(negedge clk);
      outs("ex0_l1", 2'b10, 4'hF, 5'd9, 32'h66, 32'h1C000204, 1'b1, 1'b0, 32'h0, 6'h0);
`endif

      // Single-lane groups back to back; first has rf_we clear.
      offer(2'b01, 32'h1C000300, 32'h0, 2'b00, 5'd12, 5'd0, 32'h99, 32'h0, 2'b00, 6'h0, 6'h0);
      @(negedge clk);
      outs("one_nowe", 2'b00, 4'h0, 5'd12, 32'h99, 32'h1C000300, 1'b1, 1'b0, 32'h0, 6'h0);
      offer(2'b01, 32'h1C000304, 32'h0, 2'b01, 5'd13, 5'd0, 32'hAB, 32'h0, 2'b00, 6'h0, 6'h0);
      @(negedge clk);
      outs("one_we", 2'b01, 4'hF, 5'd13, 32'hAB, 32'h1C000304, 1'b1, 1'b0, 32'h0, 6'h0);
      idle();
      @(negedge clk);
      check("rf_r12", rf_model[12], 32'h0);

      // Reset during EMIT0 of a two-lane group.
      offer(2'b11, 32'h1C000400, 32'h1C000404, 2'b11, 5'd10, 5'd11, 32'h77, 32'h88, 2'b00, 6'h0, 6'h0);
      @(negedge clk);
      outs("rst_l0", 2'b01, 4'hF, 5'd10, 32'h77, 32'h1C000400, 1'b0, 1'b0, 32'h0, 6'h0);
      reset = 1'b1;
      idle();
      @(negedge clk);
      reset = 1'b0;
      outs("rst_mid", 2'b00, 4'h0, 5'd0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, 6'h0);
      @(negedge clk);
      outs("rst_mid2", 2'b00, 4'h0, 5'd0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, 6'h0);
      check("rf_r11", rf_model[11], 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/wb_stage_mlane.md
# wb_stage_mlane

Parametrised writeback stage for the multi-issue pipeline; sits after MEM and commits up to LANES instructions per group to the register file. It keeps the single-port debug trace interface by retiring one lane per cycle, and stalls MEM with `ws_allowin` while a group drains. It resolves exceptions in program order: a faulting lane kills itself and all younger lanes, and the block pulses `ws_flush` with the fault PC and ecode.

## Interface
- LANES, 2, lanes per group; legal values 1 or 2
- DATA_W, 32, register data width
- AW, 5, register address width
- PC_W, 32, PC width
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset (one clock; reset is synchronous and active-high)
- ws_allowin  out  1  WB can accept a group this cycle
- ms_to_ws_valid  in  1  MEM offers a group
- ms_lane_valid  in  LANES  per-lane occupancy; lane 0 must be set when the group is valid
- ms_pc  in  LANES*PC_W  per-lane PC; lane i occupies bits [i*PC_W +: PC_W]
- ms_rf_we  in  LANES  per-lane register write enable
- ms_rf_waddr  in  LANES*AW  per-lane destination register
- ms_rf_wdata  in  LANES*DATA_W  per-lane write data
- ms_ex  in  LANES  per-lane exception flag
- ms_ecode  in  LANES*6  per-lane exception code
- ws_rf_we  out  LANES  regfile write strobe, one lane per cycle
- ws_rf_waddr  out  LANES*AW  regfile address
- ws_rf_wdata  out  LANES*DATA_W  regfile data
- ws_flush  out  1  one-cycle exception flush pulse
- ws_ex_pc  out  PC_W  PC of the faulting lane; valid while ws_flush is high
- ws_ecode  out  6  ecode of the faulting lane; valid while ws_flush is high
- debug_wb_pc  out  32  trace PC of the lane retiring this cycle
- debug_wb_rf_we  out  4  trace write enable, replicated across all 4 bits
- debug_wb_rf_wnum  out  5  trace register number
- debug_wb_rf_wdata  out  32  trace write data

## Operation
- Capture: on `ms_to_ws_valid && ws_allowin`, latch all lane fields and set `ws_valid`.
- Fault lane F = lowest i with `ms_lane_valid[i] && ms_ex[i]`.
- Retire set R = valid lanes with index < F, or all valid lanes when there is no fault.
- Lanes in R retire in ascending index order, one per cycle, independent of `rf_we`.
- States:
  - IDLE: no group held.
  - EMIT0: lane 0 retiring, or the fault-only cycle when R is empty.
  - EMIT1: lane 1 retiring.
- Transitions:
  - IDLE -> EMIT0 on capture.
  - EMIT0 -> EMIT1 when lane 1 is in R.
  - Otherwise the group completes: go to EMIT0 on a new capture, else IDLE.
  - EMIT1 completes the group the same way.
- Completion cycle: the last state of the group. `ws_ready_go` is 1 only in this cycle.
- `ws_allowin = !ws_valid || (ws_ready_go && !ws_flush)`.
- Outputs in a retire cycle for lane i:
  - `ws_rf_we[i] = rf_we[i]`; all other lanes' strobes are 0.
  - Debug outputs carry lane i's PC, address and data.
  - `debug_wb_rf_we = {4{rf_we[i]}}`.
- Fault-only cycle (R empty): `ws_rf_we = 0`, `debug_wb_rf_we = 0`, `debug_wb_pc` = fault PC.
- The faulting lane never writes the regfile.
- `ws_flush` is high in the completion cycle of a group with a fault. `ws_ex_pc` and `ws_ecode` come from lane F.
- After a flush, `ws_allowin` is 0 for that cycle, so WB holds one bubble. MEM must drop its contents on `ws_flush`.
- Same destination register in both lanes: lane 1 writes one cycle later and wins.
- A write to r0 passes through unchanged; the regfile ignores it.
- Reset values: `ws_valid = 0`, state IDLE, `ws_allowin = 1`. All other outputs 0, including latched fields.
- Reset mid-group: the group is discarded with no further writes or flush pulse.

## Timing
- Capture-to-first-retire latency: 1 cycle. The registered group is visible the cycle after the handshake.
- Cycles per group: max(1, |R|). LANES=1 always takes 1 cycle.
- `ws_allowin` is combinational from state; no combinational path from `ms_*` to outputs.
- Back-to-back groups without a fault sustain 1 group per |R| cycles with no bubble.

## Configuration
- `WB_EXCEPTION_EN` defined:
  - Fault and kill logic as above.
  - `ws_flush`, `ws_ex_pc` and `ws_ecode` are live.
- `WB_EXCEPTION_EN` undefined:
  - `ms_ex` and `ms_ecode` are ignored; R = all valid lanes.
  - `ws_flush`, `ws_ex_pc` and `ws_ecode` are tied to 0.
  - No flush bubble.

## Test plan
- Reset held 2 cycles, then released -> `ws_allowin = 1`, every other output 0, no trace write.
- LANES=2 group: lane0 r3←0x11, lane1 r4←0x22 -> cycle 1: trace r3/0x11, `ws_allowin = 0`; cycle 2: trace r4/0x22, `ws_allowin = 1`.
- Both lanes target r5: lane0 0xAAAA, lane1 0xBBBB -> regfile r5 ends as 0xBBBB; trace shows both writes in order.
- Lane1 `ms_ex = 1`, ecode 0x0B, pc 0x1C000104 -> lane0 retires; `ws_flush` high 1 cycle with `ws_ex_pc = 0x1C000104` and `ws_ecode = 0x0B`; no lane1 write; next cycle `ws_allowin = 1`, `ws_valid = 0`.
- Lane0 fault with lane1 valid -> single cycle; `ws_rf_we = 0`; flush with lane0 PC; lane1 killed.
- Reset asserted in EMIT0 of a 2-lane group -> next cycle IDLE, lane1 never written, `ws_flush` stays 0.
